// File: rtl/cic_integ_decim.sv
// CIC integrator + decimator: wrapping signed accumulator, emits every 2^os_sel accepted samples.
// Latency: the R-th accepted sample appears on data_out one clk after it is accepted.
// No backpressure: every dout_valid strobe must be taken by the comb stage.
module cic_integ_decim #(
  parameter int IW   = 4,
  parameter int ACCW = 23,
  parameter int FW   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      os_sel,
  input  logic            din_valid,
  input  logic [IW-1:0]   din,
  output logic            dout_valid,
  output logic [ACCW-1:0] data_out,
  output logic [FW-1:0]   flag_out
);

  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_n;
  logic [ACCW-1:0] din_ext;
  logic [5:0]      cnt;
  logic [5:0]      r_m1;
  logic [2:0]      os_sel_q;
  logic [FW-1:0]   flag;
  logic [FW-1:0]   flag_n;
  logic            enabled;
  logic            changed;
  logic            accept;
  logic            ovf;
  logic            unf;
  logic            last;

  assign enabled = (os_sel != 3'd0) && (os_sel != 3'd7);
  assign changed = (os_sel != os_sel_q);
  assign accept  = din_valid && enabled && !changed;

  assign din_ext = {{(ACCW-IW){din[IW-1]}}, din};
  assign acc_n   = acc + din_ext;

  // Signed wrap: two same-sign operands producing the opposite sign.
  assign ovf = !acc[ACCW-1] && !din[IW-1] &&  acc_n[ACCW-1];
  assign unf =  acc[ACCW-1] &&  din[IW-1] && !acc_n[ACCW-1];

  // Next wrap flag: bit 1 records direction, bit 0 toggles once per wrap.
  always_comb begin
    flag_n = flag;
    if (ovf) begin
      flag_n = {1'b0, ~flag[0]};
    end else if (unf) begin
      flag_n = {1'b1, ~flag[0]};
    end
  end

  // Terminal count R-1 for the current decimation ratio; only used while enabled.
  always_comb begin
    r_m1 = 6'd0;
    case (os_sel)
      3'd1: r_m1 = 6'd1;
      3'd2: r_m1 = 6'd3;
      3'd3: r_m1 = 6'd7;
      3'd4: r_m1 = 6'd15;
      3'd5: r_m1 = 6'd31;
      3'd6: r_m1 = 6'd63;
      default: r_m1 = 6'd0;
    endcase
  end

  assign last = (cnt == r_m1);

  // Track the previous ratio select so a change can restart the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_sel_q <= 3'd0;
    end else begin
      os_sel_q <= os_sel;
    end
  end

  // Integrate, count accepted samples and register the decimated output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      cnt        <= 6'd0;
      flag       <= '0;
      data_out   <= '0;
      flag_out   <= '0;
      dout_valid <= 1'b0;
    end else if (!enabled) begin
      // Disabled: everything cleared, matching the comb stage's history clear.
      acc        <= '0;
      cnt        <= 6'd0;
      flag       <= '0;
      data_out   <= '0;
      flag_out   <= '0;
      dout_valid <= 1'b0;
    end else if (changed) begin
      // Ratio change: drop the partial frame, keep the last emitted output.
      acc        <= '0;
      cnt        <= 6'd0;
      flag       <= '0;
      dout_valid <= 1'b0;
    end else if (accept) begin
      acc  <= acc_n;
      flag <= flag_n;
      if (last) begin
        // Accumulator keeps running across emits; comb stage differences outputs.
        cnt        <= 6'd0;
        data_out   <= acc_n;
        flag_out   <= flag_n;
        dout_valid <= 1'b1;
      end else begin
        cnt        <= cnt + 6'd1;
        dout_valid <= 1'b0;
      end
    end else begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_integ_decim.sv
// Directed bench for cic_integ_decim: full-width instance plus an 8-bit one for wrap cases.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Expected values are hand-computed from the stimulus in each step.
module tb_cic_integ_decim;

  logic        clk;
  logic        reset_n;
  logic [2:0]  os_sel;
  logic        din_valid;
  logic [3:0]  din;

  logic        dout_valid;
  logic [22:0] data_out;
  logic [1:0]  flag_out;

  logic        dout_valid8;
  logic [7:0]  data_out8;
  logic [1:0]  flag_out8;

  int checks;
  int failures;
  int n;
  bit vld;

  cic_integ_decim #(.IW(4), .ACCW(23), .FW(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .os_sel     (os_sel),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .data_out   (data_out),
    .flag_out   (flag_out)
  );

  cic_integ_decim #(.IW(4), .ACCW(8), .FW(2)) dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .os_sel     (os_sel),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid8),
    .data_out   (data_out8),
    .flag_out   (flag_out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    os_sel    = 3'd0;
    din_valid = 1'b0;
    din       = 4'd0;

    // Reset state
    step();
    step();
    check("rst_dv",   int'(dout_valid), 0);
    check("rst_data", int'($signed(data_out)), 0);
    check("rst_flag", int'(flag_out), 0);
    reset_n = 1'b1;

    // T2: R=2, +1 every clock; first edge is the select-change cycle
    os_sel    = 3'd1;
    din_valid = 1'b1;
    din       = 4'd1;
    step();
    check("t2_chg_dv", int'(dout_valid), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t2_dv", int'(dout_valid), (k % 2 == 0) ? 1 : 0);
      check("t2_data", int'($signed(data_out)), (k % 2 == 0) ? k : k - 1);
      check("t2_flag", int'(flag_out), 0);
    end

    // T1: async reset mid-stream, outputs clear without a clock edge
    step();
    reset_n = 1'b0;
    #2;
    check("t1_async_dv",   int'(dout_valid), 0);
    check("t1_async_data", int'($signed(data_out)), 0);
    check("t1_async_flag", int'(flag_out), 0);
    #1;
    reset_n = 1'b1;
    step();
    check("t1_chg_dv", int'(dout_valid), 0);
    step();
    check("t1_s1_dv", int'(dout_valid), 0);
    step();
    check("t1_s2_dv",   int'(dout_valid), 1);
    check("t1_s2_data", int'($signed(data_out)), 2);

    // T3: R=8, din=-2 on one cycle in three
    os_sel = 3'd3;
    din    = 4'b1110;
    step();
    check("t3_chg_dv", int'(dout_valid), 0);
    n = 0;
    for (int c = 0; c < 48; c++) begin
      vld       = (c % 3 == 0);
      din_valid = vld;
      step();
      if (vld) n++;
      check("t3_dv", int'(dout_valid), (vld && (n % 8 == 0)) ? 1 : 0);
      if (vld && (n % 8 == 0)) begin
        check("t3_data", int'($signed(data_out)), -2 * n);
        check("t3_flag", int'(flag_out), 0);
      end
    end

    // T5: R=4 for 3 samples, then switch to R=16; partial frame discarded
    os_sel    = 3'd2;
    din       = 4'd3;
    din_valid = 1'b1;
    step();
    check("t5_chg1_dv",   int'(dout_valid), 0);
    check("t5_chg1_hold", int'($signed(data_out)), -32);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("t5_pre_dv", int'(dout_valid), 0);
    end
    os_sel = 3'd4;
    step();
    check("t5_chg2_dv",   int'(dout_valid), 0);
    check("t5_chg2_hold", int'($signed(data_out)), -32);
    for (int k = 1; k <= 16; k++) begin
      step();
      check("t5_dv", int'(dout_valid), (k == 16) ? 1 : 0);
    end
    check("t5_data", int'($signed(data_out)), 48);
    check("t5_flag", int'(flag_out), 0);

    // T6: disabled selects clear outputs and ignore din
    os_sel = 3'd0;
    din    = 4'd5;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_dv0",   int'(dout_valid), 0);
      check("t6_data0", int'($signed(data_out)), 0);
      check("t6_flag0", int'(flag_out), 0);
    end
    os_sel = 3'd7;
    for (int k = 0; k < 2; k++) begin
      step();
      check("t6_dv7",   int'(dout_valid), 0);
      check("t6_data7", int'($signed(data_out)), 0);
    end

    // T4: 8-bit integrator, +7 x20 overflows at sample 19, then -7 underflows at 22
    os_sel = 3'd1;
    din    = 4'd7;
    step();
    check("t4_chg_dv", int'(dout_valid8), 0);
    for (int k = 1; k <= 24; k++) begin
      din = (k <= 20) ? 4'd7 : 4'b1001;
      step();
      check("t4_dv", int'(dout_valid8), (k % 2 == 0) ? 1 : 0);
      case (k)
        18: begin
          check("t4_s18_data", int'($signed(data_out8)), 126);
          check("t4_s18_flag", int'(flag_out8), 0);
        end
        20: begin
          check("t4_s20_data", int'($signed(data_out8)), -116);
          check("t4_s20_flag", int'(flag_out8), 1);
        end
        22: begin
          check("t4_s22_data", int'($signed(data_out8)), 126);
          check("t4_s22_flag", int'(flag_out8), 2);
        end
        24: begin
          check("t4_s24_data", int'($signed(data_out8)), 112);
          check("t4_s24_flag", int'(flag_out8), 2);
        end
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
